// File: rtl/reg_wb_queue_if.sv
// Bundle of the write-back queue's producer, register-file and lookup signals.
// master: the surrounding pipeline (drives requests, lookup, flush).
// slave:  the queue itself.
interface reg_wb_queue_if #(
  parameter int AW = 2
);
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  lk_reg;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic [AW:0] count;

  modport master (
    output flush, in_valid, in_reg, in_data, lk_reg,
    input  in_ready, wr_en, wr_reg, wr_data, lk_hit, lk_data, count
  );

  modport slave (
    input  flush, in_valid, in_reg, in_data, lk_reg,
    output in_ready, wr_en, wr_reg, wr_data, lk_hit, lk_data, count
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Requests from variable-latency producers are queued and retired one per
// cycle, oldest first. The head entry is presented combinationally from
// registered state so it is stable across the register file's negedge write.
// A lookup port returns the youngest pending value for a given register.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic           CLK,
  input  logic           Reset,
  reg_wb_queue_if.slave  bus
);

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;

  logic empty;
  logic full;
  logic push;
  logic push_enq;
  logic pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));

  // A $0 request completes its handshake but is never stored.
  assign push     = bus.in_valid && !full && !bus.flush;
  assign push_enq = push && (bus.in_reg != 5'd0);
  // The register file always accepts, so any valid head retires each cycle.
  assign pop      = !empty && !bus.flush;

  assign bus.in_ready = !full;
  assign bus.count    = cnt;

  // Pointer and occupancy update; flush takes priority over push and pop.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push_enq) - (AW+1)'(pop);
    end
  end

  // Entry storage write at the tail.
  // NOTE: the entry array is deliberately not reset; validity is tracked
  // solely by the pointers and count, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (push_enq) begin
      mem[wr_ptr] <= '{dst: bus.in_reg, data: bus.in_data};
    end
  end

  // Head entry drives the register file port; zeros while empty.
  assign bus.wr_en   = !empty;
  assign bus.wr_reg  = empty ? 5'd0  : mem[rd_ptr].dst;
  assign bus.wr_data = empty ? 32'd0 : mem[rd_ptr].data;

  // Lookup: walk valid entries oldest to youngest so the last match wins.
  always_comb begin
    logic [AW-1:0] idx;
    // NOTE: every output gets a default before the loop so no latch is
    // inferred when nothing matches.
    bus.lk_hit  = 1'b0;
    bus.lk_data = 32'd0;
    idx         = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (((AW+1)'(i) < cnt) && (bus.lk_reg != 5'd0) &&
          (mem[idx].dst == bus.lk_reg)) begin
        bus.lk_hit  = 1'b1;
        bus.lk_data = mem[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue. A queue-based model of pending writes is
// compared against every DUT output on each negedge; literal expectations at
// key points pin the model itself.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
  } mentry_t;

  logic CLK;
  logic Reset;

  reg_wb_queue_if #(.AW(AW)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  mentry_t     model_q[$];
  logic [4:0]  issued[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of pending writes, oldest at index 0.
  always @(posedge CLK or negedge Reset) begin
    int sz;
    if (!Reset) begin
      model_q.delete();
    end else if (bus.flush) begin
      model_q.delete();
    end else begin
      sz = model_q.size();
      if (sz > 0) model_q.delete(0);
      if (bus.in_valid && sz < DEPTH && bus.in_reg != 5'd0)
        model_q.push_back('{bus.in_reg, bus.in_data});
    end
  end

  // Compare every DUT output against the model, mid-cycle.
  always @(negedge CLK) begin
    logic        e_hit;
    logic [31:0] e_data;
    int          n;
    n      = model_q.size();
    e_hit  = 1'b0;
    e_data = 32'd0;
    if (bus.lk_reg != 5'd0) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (!e_hit && model_q[i].dst == bus.lk_reg) begin
          e_hit  = 1'b1;
          e_data = model_q[i].data;
        end
      end
    end
    check("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
    check("count",    32'(bus.count),    32'(n));
    check("wr_en",    32'(bus.wr_en),    32'(n > 0));
    check("wr_reg",   32'(bus.wr_reg),   (n > 0) ? 32'(model_q[0].dst) : 32'd0);
    check("wr_data",  bus.wr_data,       (n > 0) ? model_q[0].data : 32'd0);
    check("lk_hit",   32'(bus.lk_hit),   32'(e_hit));
    check("lk_data",  bus.lk_data,       e_data);
    if (bus.wr_en === 1'b1) issued.push_back(bus.wr_reg);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int nine_seen;
    Reset        = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_reg   = 5'd5;
    bus.in_data  = 32'h1111_1111;
    bus.lk_reg   = 5'd0;

    // Test 1: reset held with a request waiting, then release.
    repeat (3) tick();
    check("t1_rst_count", 32'(bus.count), 32'd0);
    check("t1_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("t1_rst_ready", 32'(bus.in_ready), 32'd1);
    Reset = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t1_wr_en",   32'(bus.wr_en), 32'd1);
    check("t1_wr_reg",  32'(bus.wr_reg), 32'd5);
    check("t1_wr_data", bus.wr_data, 32'h1111_1111);
    tick();
    check("t1_idle_wr_en", 32'(bus.wr_en), 32'd0);
    check("t1_idle_count", 32'(bus.count), 32'd0);

    // Test 2: r1..r4 twice back to back; pointers wrap twice.
    issued.delete();
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_reg   = 5'((k % 4) + 1);
      bus.in_data  = 32'hA1 + 32'(k % 4);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();
    check("t2_issued_n", 32'(issued.size()), 32'd8);
    for (int k = 0; k < 8 && k < issued.size(); k++)
      check("t2_order", 32'(issued[k]), 32'((k % 4) + 1));

    // Test 3: a $0 request is accepted but never queued or looked up.
    bus.in_valid = 1'b1;
    bus.in_reg   = 5'd0;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.lk_reg   = 5'd0;
    check("t3_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("t3_count",  32'(bus.count), 32'd0);
    check("t3_wr_en",  32'(bus.wr_en), 32'd0);
    check("t3_lk_hit", 32'(bus.lk_hit), 32'd0);

    // Test 4: two writes to r7; lookup sees the youngest stored value.
    bus.lk_reg   = 5'd7;
    bus.in_valid = 1'b1;
    bus.in_reg   = 5'd7;
    bus.in_data  = 32'h1;
    tick();
    bus.in_data  = 32'h2;
    check("t4_hit_a",  32'(bus.lk_hit), 32'd1);
    check("t4_data_a", bus.lk_data, 32'h1);
    tick();
    bus.in_valid = 1'b0;
    check("t4_hit_b",  32'(bus.lk_hit), 32'd1);
    check("t4_data_b", bus.lk_data, 32'h2);
    tick();
    check("t4_hit_c",  32'(bus.lk_hit), 32'd0);
    check("t4_data_c", bus.lk_data, 32'h0);
    bus.lk_reg = 5'd0;

    // Test 5: flush with a concurrent request; head still presented.
    issued.delete();
    bus.in_valid = 1'b1;
    bus.in_reg   = 5'd3;
    bus.in_data  = 32'h33;
    tick();
    bus.flush    = 1'b1;
    bus.in_reg   = 5'd9;
    bus.in_data  = 32'h9;
    check("t5_head_en",  32'(bus.wr_en), 32'd1);
    check("t5_head_reg", 32'(bus.wr_reg), 32'd3);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_count", 32'(bus.count), 32'd0);
    check("t5_wr_en", 32'(bus.wr_en), 32'd0);
    repeat (2) tick();
    nine_seen = 0;
    foreach (issued[k]) if (issued[k] == 5'd9) nine_seen++;
    check("t5_no_r9", 32'(nine_seen), 32'd0);

    // Test 6: asynchronous reset mid-cycle with an entry pending.
    bus.in_valid = 1'b1;
    bus.in_reg   = 5'd6;
    bus.in_data  = 32'h66;
    tick();
    bus.in_valid = 1'b0;
    check("t6_pending", 32'(bus.wr_en), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("t6_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("t6_rst_count", 32'(bus.count), 32'd0);
    tick();
    Reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_reg   = 5'd8;
    bus.in_data  = 32'h88;
    tick();
    bus.in_valid = 1'b0;
    check("t6_wr_reg",  32'(bus.wr_reg), 32'd8);
    check("t6_wr_data", bus.wr_data, 32'h88);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
